// File: rtl/matrix_result_capture.sv
// Captures Datapath stores that land in the result-matrix window, queues {index, data}, drains over valid/ready.
// Build with RESULT_CHECKSUM_EN defined to get a wrap-around sum of all counted hit data on Checksum.
module matrix_result_capture #(
  parameter int          N         = 4,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    WrEn,
  input  logic [31:0]             WrAddr,
  input  logic [31:0]             Writedata,
  output logic [31:0]             OutData,
  output logic [$clog2(N*N)-1:0]  OutIndex,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    Done,
  output logic                    Overflow,
  output logic [31:0]             Checksum
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(NN + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * NN);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_FINISHED} state_t;

  state_t        state;
  logic [IW-1:0] idx_mem [DEPTH];
  logic [31:0]   dat_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic [CW-1:0] cap_cnt, cnt_nxt;
  logic [31:0]   offset;
  logic [IW-1:0] hit_idx;
  logic          hit, accept, full, pop, push, drop;

  always_comb begin
    offset  = WrAddr - BASE_ADDR;
    hit_idx = IW'(offset >> 2);
    hit     = WrEn && (WrAddr[1:0] == 2'b00) && (WrAddr >= BASE_ADDR) && ({1'b0, WrAddr} < END_ADDR);
    accept  = hit && ((state == S_IDLE) || (state == S_CAPTURE));
    full    = (occ == OW'(DEPTH));
    pop     = OutValid && OutReady;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    push    = accept && (!full || pop);
    drop    = accept && full && !pop;
    cnt_nxt = (accept && (cap_cnt != CW'(NN))) ? cap_cnt + CW'(1) : cap_cnt;
  end

  assign OutValid = (occ != '0);
  assign OutData  = OutValid ? dat_mem[rd_ptr] : '0;
  assign OutIndex = OutValid ? idx_mem[rd_ptr] : '0;

  always_ff @(posedge Clk) begin
    if (push) begin
      idx_mem[wr_ptr] <= hit_idx;
      dat_mem[wr_ptr] <= Writedata;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      cap_cnt  <= '0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
      if (drop) Overflow <= 1'b1;
      cap_cnt <= cnt_nxt;
      case (state)
        S_IDLE, S_CAPTURE: begin
          if (cnt_nxt == CW'(NN)) state <= S_DRAIN;
          else if (accept)        state <= S_CAPTURE;
        end
        S_DRAIN: begin
          if (occ == '0) begin
            state <= S_FINISHED;
            Done  <= 1'b1;
          end
        end
        S_FINISHED: ;
      endcase
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [31:0] sum;
  always_ff @(posedge Clk) begin
    if (!Reset)      sum <= '0;
    else if (accept) sum <= sum + Writedata;
  end
  assign Checksum = sum;
`else
  assign Checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_result_capture.sv
// Randomized bench for matrix_result_capture against a queue-based reference model.
module tb_matrix_result_capture;
  localparam int          N     = 4;
  localparam int          DEPTH = 8;
  localparam int          NN    = N * N;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        Clk = 1'b0;
  logic        Reset, WrEn, OutReady;
  logic [31:0] WrAddr, Writedata, OutData, Checksum;
  logic [3:0]  OutIndex;
  logic        OutValid, Done, Overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          idx;
    logic [31:0] dat;
  } ent_t;

  ent_t        mq[$];
  int          m_cnt;
  bit          m_ovf, m_done;
  logic [31:0] m_sum;

  matrix_result_capture #(.N(N), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .Writedata(Writedata),
    .OutData(OutData), .OutIndex(OutIndex), .OutValid(OutValid), .OutReady(OutReady),
    .Done(Done), .Overflow(Overflow), .Checksum(Checksum)
  );

  always #5 Clk = ~Clk;

  function automatic bit in_window(input logic we, input logic [31:0] a);
    return we && (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'(4 * NN));
  endfunction

  function automatic logic [31:0] exp_checksum();
`ifdef RESULT_CHECKSUM_EN
    return m_sum;
`else
    return 32'h0;
`endif
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle 1 time unit past it.
  task automatic cycle(input logic rst_n, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    bit pop, acc;
    Reset = rst_n; WrEn = we; WrAddr = a; Writedata = d; OutReady = rdy;
    @(posedge Clk);
    if (!rst_n) begin
      mq.delete(); m_cnt = 0; m_ovf = 0; m_done = 0; m_sum = 0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      acc = in_window(we, a) && (m_cnt < NN);
      if (m_cnt == NN && mq.size() == 0) m_done = 1;
      if (acc) begin
        m_cnt++;
        m_sum += d;
        if (mq.size() < DEPTH || pop) mq.push_back('{int'((a - BASE) >> 2), d});
        else m_ovf = 1;
      end
      if (pop) void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, BASE, 32'h1234, 1);
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", OutValid); end
    n_checks++; if (OutData !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", OutData); end
    n_checks++; if (OutIndex !== 4'h0) begin n_fail++; $display("FAIL reset_index: got %h want 0", OutIndex); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", Overflow); end
    n_checks++; if (Checksum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", Checksum); end
  endtask

  task automatic test_in_order();
    int got = 0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < NN; i++) begin
      cycle(1, 1, BASE + 32'(4 * i), 32'(i + 1), 1);
      n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL order_valid[%0d]: got %b want 1", i, OutValid); end
      if (OutValid === 1'b1) begin
        n_checks++; if (OutData !== 32'(got + 1)) begin n_fail++; $display("FAIL order_data: got %0d want %0d", OutData, got + 1); end
        n_checks++; if (OutIndex !== 4'(got)) begin n_fail++; $display("FAIL order_index: got %0d want %0d", OutIndex, got); end
        got++;
      end
    end
    cycle(1, 0, 0, 0, 1);
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL order_empty: got %b want 0", OutValid); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL order_done_early: got %b want 0", Done); end
    cycle(1, 0, 0, 0, 1);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL order_done: got %b want 1", Done); end
    n_checks++; if (got !== NN) begin n_fail++; $display("FAIL order_count: got %0d want %0d", got, NN); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL order_ovf: got %b want 0", Overflow); end
`ifdef RESULT_CHECKSUM_EN
    n_checks++; if (Checksum !== 32'd136) begin n_fail++; $display("FAIL order_sum: got %0d want 136", Checksum); end
`else
    n_checks++; if (Checksum !== 32'd0) begin n_fail++; $display("FAIL order_sum: got %0d want 0", Checksum); end
`endif
  endtask

  task automatic test_after_done();
    logic [31:0] sum_before;
    sum_before = exp_checksum();
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, BASE, 32'hFFFF_FFFF, 1);
      n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL post_done_valid: got %b want 0", OutValid); end
      n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL post_done_done: got %b want 1", Done); end
      n_checks++; if (Checksum !== sum_before) begin n_fail++; $display("FAIL post_done_sum: got %h want %h", Checksum, sum_before); end
    end
  endtask

  // Randomized hits mixed with ignorable stores and random OutReady, checked cycle-by-cycle until Done.
  task automatic test_random_run(input int n_hits, input int rdy_pct);
    int hits = 0;
    int budget = 0;
    logic [31:0] a;
    logic we;
    while (!(hits == n_hits && m_done && mq.size() == 0) && budget < 2000) begin
      we = 1'b1;
      if (hits < n_hits && $urandom_range(99) < 60) begin
        a = BASE + 32'(4 * $urandom_range(NN - 1));
        hits++;
      end else begin
        case ($urandom_range(3))
          0: begin we = 1'b0; a = BASE + 32'(4 * $urandom_range(NN - 1)); end
          1: a = BASE + 32'(4 * $urandom_range(NN - 1)) + 32'($urandom_range(3, 1));
          2: a = BASE - 32'(4 * $urandom_range(8, 1));
          default: a = BASE + 32'(4 * NN) + 32'(4 * $urandom_range(8));
        endcase
      end
      cycle(1, we, a, $urandom, 1'($urandom_range(99) < rdy_pct));
      budget++;
      n_checks++; if (OutValid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid: got %b want %b", OutValid, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_checks++; if (OutData !== mq[0].dat) begin n_fail++; $display("FAIL rand_data: got %h want %h", OutData, mq[0].dat); end
        n_checks++; if (OutIndex !== 4'(mq[0].idx)) begin n_fail++; $display("FAIL rand_index: got %0d want %0d", OutIndex, mq[0].idx); end
      end
      n_checks++; if (Done !== m_done) begin n_fail++; $display("FAIL rand_done: got %b want %b", Done, m_done); end
      n_checks++; if (Overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf: got %b want %b", Overflow, m_ovf); end
      n_checks++; if (Checksum !== exp_checksum()) begin n_fail++; $display("FAIL rand_sum: got %h want %h", Checksum, exp_checksum()); end
    end
    n_checks++; if (budget >= 2000) begin n_fail++; $display("FAIL rand_timeout: Done=%b never completed within 2000 cycles", Done); end
  endtask

  task automatic test_ignored();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 32'h0000_00FC, $urandom, 1);
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL ign_below: got %b want 0", OutValid); end
    cycle(1, 1, 32'h0000_0140, $urandom, 1);
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL ign_above: got %b want 0", OutValid); end
    cycle(1, 1, 32'h0000_0102, $urandom, 1);
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL ign_misaligned: got %b want 0", OutValid); end
    cycle(1, 0, 32'h0000_0104, $urandom, 1);
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL ign_no_wren: got %b want 0", OutValid); end
    n_checks++; if (Checksum !== 32'h0) begin n_fail++; $display("FAIL ign_sum: got %h want 0", Checksum); end
    test_random_run(NN, 70);
  endtask

  task automatic test_overflow();
    int pops = 0;
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 1, BASE + 32'(4 * i), 32'hA0 + 32'(i), 0);
    n_checks++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", Overflow); end
    n_checks++; if (OutData !== 32'hA0) begin n_fail++; $display("FAIL ovf_head: got %h want a0", OutData); end
    for (int c = 0; c < 12; c++) begin
      if (OutValid === 1'b1) begin
        n_checks++; if (OutData !== 32'hA0 + 32'(pops)) begin n_fail++; $display("FAIL ovf_drain_data: got %h want %h", OutData, 32'hA0 + 32'(pops)); end
        pops++;
      end
      cycle(1, 0, 0, 0, 1);
    end
    n_checks++; if (pops !== 8) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 8", pops); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL ovf_done_early: got %b want 0", Done); end
    for (int i = 9; i < NN; i++) cycle(1, 1, BASE + 32'(4 * i), 32'hB0 + 32'(i), 1);
    for (int c = 0; c < 20 && Done !== 1'b1; c++) cycle(1, 0, 0, 0, 1);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %b want 1", Done); end
    n_checks++; if (Checksum !== exp_checksum()) begin n_fail++; $display("FAIL ovf_sum: got %h want %h", Checksum, exp_checksum()); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_q[$];
    logic [31:0] d;
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      cycle(1, 1, BASE + 32'(4 * i), d, 0);
    end
    cycle(1, 1, BASE + 32'(4 * DEPTH), 32'hBEEF, 1);
    void'(exp_q.pop_front());
    exp_q.push_back(32'hBEEF);
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", Overflow); end
    for (int c = 0; c < 12; c++) begin
      if (OutValid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL fullpop_extra: got %h want no entry", OutData); end
        else if (OutData !== exp_q[0]) begin n_fail++; $display("FAIL fullpop_data: got %h want %h", OutData, exp_q[0]); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      cycle(1, 0, 0, 0, 1);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fullpop_missing: got %0d left want 0", exp_q.size()); end
    test_random_run(NN - DEPTH - 1, 50);
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, BASE + 32'(4 * $urandom_range(NN - 1)), $urandom, 1'(i == 1 || i == 2));
    n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before: got %b want 1", OutValid); end
    cycle(0, 1, BASE, $urandom, 1);
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", OutValid); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", Done); end
    n_checks++; if (Checksum !== 32'h0) begin n_fail++; $display("FAIL mid_sum: got %h want 0", Checksum); end
    n_checks++; if (OutData !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0", OutData); end
    test_random_run(NN, 60);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_after_done();
    test_ignored();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    cycle(0, 0, 0, 0, 0);
    test_random_run(NN, 25);
    test_after_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
